// File: rtl/mux_nx1_scan_if.sv
// rtl/mux_nx1_scan_if.sv - source/consumer bundle for the N-channel scan multiplexer
interface mux_nx1_scan_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic              EN;
  logic              MODE;
  logic [SEL_W-1:0]  S;
  logic [N_CH*W-1:0] I;
  logic [W-1:0]      O;
  logic              O_VALID;
  logic [SEL_W-1:0]  CH;
  logic              WRAP;

  modport master (
    output EN, MODE, S, I,
    input  O, O_VALID, CH, WRAP
  );

  modport slave (
    input  EN, MODE, S, I,
    output O, O_VALID, CH, WRAP
  );
endinterface

// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - N-channel W-bit registered mux with manual select and dwell-timed round-robin scan
module mux_nx1_scan #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_nx1_scan_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [DW_W-1:0]  dwell_q;
  logic [W-1:0]     o_q;
  logic             o_valid_q;
  logic [SEL_W-1:0] ch_q;
  logic             wrap_q;

  logic [W-1:0]     man_data;
  logic             man_hit;
  logic [W-1:0]     scan_data;
  logic [SEL_W-1:0] scan_ptr;
  logic [DW_W-1:0]  scan_dwell;

  // Entering SCAN restarts at channel 0 with a full dwell, so the effective
  // pointer/dwell are forced to zero on the entry edge.
  always_comb begin
    state_d    = bus.MODE ? SCAN : MAN;
    scan_ptr   = (state_q == SCAN) ? ptr_q   : '0;
    scan_dwell = (state_q == SCAN) ? dwell_q : '0;
    man_data   = '0;
    man_hit    = 1'b0;
    scan_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.S == SEL_W'(k)) begin
        man_data = bus.I[k*W +: W];
        man_hit  = 1'b1;
      end
      if (scan_ptr == SEL_W'(k)) begin
        scan_data = bus.I[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      dwell_q   <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      ch_q      <= '0;
      wrap_q    <= 1'b0;
    end else if (!bus.EN) begin
      o_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == MAN) begin
        // Unpopulated select codes (non-power-of-2 N_CH) yield invalid zero data.
        o_q       <= man_hit ? man_data : '0;
        o_valid_q <= man_hit;
        ch_q      <= bus.S;
        ptr_q     <= '0;
        dwell_q   <= '0;
        wrap_q    <= 1'b0;
      end else begin
        o_q       <= scan_data;
        o_valid_q <= 1'b1;
        ch_q      <= scan_ptr;
        if (scan_dwell == DWELL_LAST) begin
          dwell_q <= '0;
          if (scan_ptr == PTR_LAST) begin
            ptr_q  <= '0;
            wrap_q <= 1'b1;
          end else begin
            ptr_q  <= scan_ptr + 1'b1;
            wrap_q <= 1'b0;
          end
        end else begin
          dwell_q <= scan_dwell + 1'b1;
          ptr_q   <= scan_ptr;
          wrap_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.O       = o_q;
  assign bus.O_VALID = o_valid_q;
  assign bus.CH      = ch_q;
  assign bus.WRAP    = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - scoreboard bench for mux_nx1_scan (8-ch and 6-ch instances)
module tb_mux_nx1_scan;
  logic clk = 1'b0;
  logic rst8 = 1'b0;
  logic rst6 = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_scan_if #(.N_CH(8), .W(4)) bus8 ();
  mux_nx1_scan_if #(.N_CH(6), .W(4)) bus6 ();

  mux_nx1_scan #(.N_CH(8), .W(4), .DWELL(2)) dut8 (.clk(clk), .rst_n(rst8), .bus(bus8.slave));
  mux_nx1_scan #(.N_CH(6), .W(4), .DWELL(2)) dut6 (.clk(clk), .rst_n(rst6), .bus(bus6.slave));

  typedef struct {
    string      name;
    logic [3:0] o;
    logic       v;
    logic [2:0] ch;
    logic       w;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic step8(input string nm, input logic rn, input logic en, input logic md,
                       input logic [2:0] s, input logic [3:0] eo, input logic ev,
                       input logic [2:0] ech, input logic ew);
    exp_t e;
    @(negedge clk);
    rst8 = rn; bus8.EN = en; bus8.MODE = md; bus8.S = s;
    e.name = nm; e.o = eo; e.v = ev; e.ch = ech; e.w = ew;
    q8.push_back(e);
  endtask

  task automatic step6(input string nm, input logic rn, input logic en, input logic md,
                       input logic [2:0] s, input logic [3:0] eo, input logic ev,
                       input logic [2:0] ech, input logic ew);
    exp_t e;
    @(negedge clk);
    rst6 = rn; bus6.EN = en; bus6.MODE = md; bus6.S = s;
    e.name = nm; e.o = eo; e.v = ev; e.ch = ech; e.w = ew;
    q6.push_back(e);
  endtask

  // Monitor: each expected entry belongs to the edge just taken.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      n_vec++;
      if (bus8.O !== e.o || bus8.O_VALID !== e.v || bus8.CH !== e.ch || bus8.WRAP !== e.w) begin
        n_bad++;
        $display("FAIL dut8 %s: got O=%h V=%b CH=%0d WRAP=%b, expected O=%h V=%b CH=%0d WRAP=%b",
                 e.name, bus8.O, bus8.O_VALID, bus8.CH, bus8.WRAP, e.o, e.v, e.ch, e.w);
      end
    end
    if (q6.size() > 0) begin
      e = q6.pop_front();
      n_vec++;
      if (bus6.O !== e.o || bus6.O_VALID !== e.v || bus6.CH !== e.ch || bus6.WRAP !== e.w) begin
        n_bad++;
        $display("FAIL dut6 %s: got O=%h V=%b CH=%0d WRAP=%b, expected O=%h V=%b CH=%0d WRAP=%b",
                 e.name, bus6.O, bus6.O_VALID, bus6.CH, bus6.WRAP, e.o, e.v, e.ch, e.w);
      end
    end
  end

  initial begin
    bus8.EN = 1'b1; bus8.MODE = 1'b1; bus8.S = 3'd0; bus8.I = 32'h8765_4321;
    bus6.EN = 1'b0; bus6.MODE = 1'b0; bus6.S = 3'd0; bus6.I = 24'h65_4321;

    // Reset held with EN/MODE active
    for (int i = 0; i < 3; i++) step8("reset", 0, 1, 1, 3'd0, 4'h0, 0, 3'd0, 0);

    // Manual select
    step8("man_s5", 1, 1, 0, 3'd5, 4'h6, 1, 3'd5, 0);
    step8("man_s2", 1, 1, 0, 3'd2, 4'h3, 1, 3'd2, 0);

    // Full scan: CH 0,0,1,1..7,7 with WRAP on the second 7
    for (int i = 0; i < 16; i++)
      step8("scan16", 1, 1, 1, 3'd0, 4'(i/2 + 1), 1, 3'(i/2), (i == 15));

    // Continue scan after wrap up to first dwell sample of CH3
    step8("post_wrap", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("scan_a", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("scan_a", 1, 1, 1, 3'd0, 4'h2, 1, 3'd1, 0);
    step8("scan_a", 1, 1, 1, 3'd0, 4'h2, 1, 3'd1, 0);
    step8("scan_a", 1, 1, 1, 3'd0, 4'h3, 1, 3'd2, 0);
    step8("scan_a", 1, 1, 1, 3'd0, 4'h3, 1, 3'd2, 0);
    step8("scan_ch3", 1, 1, 1, 3'd0, 4'h4, 1, 3'd3, 0);

    // EN gating: hold O/CH, drop valid
    for (int i = 0; i < 4; i++) step8("en_low", 1, 0, 1, 3'd0, 4'h4, 0, 3'd3, 0);
    step8("en_resume3", 1, 1, 1, 3'd0, 4'h4, 1, 3'd3, 0);
    step8("en_resume4", 1, 1, 1, 3'd0, 4'h5, 1, 3'd4, 0);
    step8("scan_b", 1, 1, 1, 3'd0, 4'h5, 1, 3'd4, 0);
    step8("scan_b", 1, 1, 1, 3'd0, 4'h6, 1, 3'd5, 0);
    step8("scan_b", 1, 1, 1, 3'd0, 4'h6, 1, 3'd5, 0);
    step8("scan_ch6", 1, 1, 1, 3'd0, 4'h7, 1, 3'd6, 0);

    // Mode switch mid-scan, then scan restarts at 0
    step8("to_man_s1", 1, 1, 0, 3'd1, 4'h2, 1, 3'd1, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h2, 1, 3'd1, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h2, 1, 3'd1, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h3, 1, 3'd2, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h3, 1, 3'd2, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h4, 1, 3'd3, 0);
    step8("rescan", 1, 1, 1, 3'd0, 4'h4, 1, 3'd3, 0);
    step8("rescan_ch4", 1, 1, 1, 3'd0, 4'h5, 1, 3'd4, 0);

    // Reset mid-scan then restart
    step8("mid_reset", 0, 1, 1, 3'd0, 4'h0, 0, 3'd0, 0);
    step8("after_rst", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("after_rst", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);
    step8("after_rst", 1, 1, 1, 3'd0, 4'h2, 1, 3'd1, 0);

    // Six-channel instance: unpopulated selects and non-power-of-2 wrap
    step6("rst6", 0, 1, 0, 3'd0, 4'h0, 0, 3'd0, 0);
    step6("man6_s3", 1, 1, 0, 3'd3, 4'h4, 1, 3'd3, 0);
    step6("man6_s7", 1, 1, 0, 3'd7, 4'h0, 0, 3'd7, 0);
    step6("man6_s6", 1, 1, 0, 3'd6, 4'h0, 0, 3'd6, 0);
    step6("man6_s5", 1, 1, 0, 3'd5, 4'h6, 1, 3'd5, 0);
    for (int i = 0; i < 12; i++)
      step6("scan6", 1, 1, 1, 3'd0, 4'(i/2 + 1), 1, 3'(i/2), (i == 11));
    step6("scan6_wrap0", 1, 1, 1, 3'd0, 4'h1, 1, 3'd0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (q8.size() > 0 || q6.size() > 0); i++) @(posedge clk);
    #2;
    if (q8.size() > 0 || q6.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q8.size() + q6.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the fixed 4:1 single-bit mux.
- Two modes:
  - manual: external select.
  - auto-scan: round-robin over all channels, with a programmable dwell per channel.
- Registered output carries a valid flag, the selected channel index and a wrap pulse.
- Sits between multi-channel sources (sensor/LED/display lanes) and a single shared consumer.

Parameters:
- N_CH, 8, number of input channels (>=2).
- W, 1, bits per channel.
- DWELL, 4, EN-qualified cycles each channel is held in scan mode (>=1).
- SEL_W, $clog2(N_CH), select/index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- EN  input  1  advance/sample enable; nothing updates when low.
- MODE  input  1  0 = manual, 1 = auto-scan.
- S  input  SEL_W  manual channel select.
- I  input  N_CH*W  packed inputs; channel k = I[k*W +: W].
- O  output  W  registered selected data.
- O_VALID  output  1  O holds valid data from channel CH.
- CH  output  SEL_W  index of channel currently driven on O.
- WRAP  output  1  one-cycle pulse when scan wraps N_CH-1 -> 0.

Behaviour:
- All outputs registered; single clock; all updates at posedge clk.
- Reset (rst_n=0 at posedge, overrides everything, including mid-scan):
  - O=0, O_VALID=0, CH=0, WRAP=0.
  - Internal ptr=0, dwell=0, state=IDLE.
- FSM states IDLE, MAN, SCAN. Transitions are evaluated only when EN=1; with EN=0 the state holds.
  - IDLE: on EN, go to MAN if MODE=0, SCAN if MODE=1.
  - MAN: on EN with MODE=1, go to SCAN.
  - SCAN: on EN with MODE=0, go to MAN.
- Latency: one cycle. Data sampled at edge t appears on O after edge t.
- EN=0: O and CH hold; O_VALID=0; WRAP=0; dwell and ptr frozen.
- Manual (EN=1, next state MAN):
  - O<=I[S]; CH<=S; O_VALID<=1.
  - S>=N_CH (non-power-of-2 N_CH): O<=0, CH<=S, O_VALID<=0.
- Scan (EN=1, next state SCAN):
  - O<=I[ptr]; CH<=ptr; O_VALID<=1.
  - If dwell==DWELL-1: dwell<=0 and ptr advances; ptr==N_CH-1 wraps to 0 and sets WRAP<=1 the same edge.
  - Otherwise dwell<=dwell+1, WRAP<=0.
  - WRAP is asserted in the cycle O shows the last dwell sample of channel N_CH-1.
- Entering SCAN from IDLE or MAN: ptr and dwell reset to 0 on that edge; channel 0 is output immediately with a full dwell.
- Leaving SCAN for MAN: ptr and dwell cleared; WRAP<=0.
- DWELL=1: channel advances every EN cycle.
- Widths:
  - dwell counter is $clog2(DWELL+1) bits.
  - No arithmetic on data; I bits pass unmodified.
- Inputs are sampled only at the edge; combinational changes between edges do not affect outputs.

Test Plan (N_CH=8, W=4, DWELL=2 unless noted):
- Reset: hold rst_n=0 for 3 cycles with EN=1, MODE=1 -> O=0, O_VALID=0, CH=0, WRAP=0 every cycle.
- Manual select:
  - I = ch k value k+1; MODE=0, EN=1, S=5 -> next cycle O=4'h6, CH=5, O_VALID=1.
  - S=2 -> O=4'h3 one cycle after S changes.
- Scan sequence: MODE=1, EN=1 for 16 cycles.
  - CH sequence 0,0,1,1,...,7,7.
  - O tracks CH+1.
  - WRAP=1 only on the second 7; next CH=0.
- EN gating: mid-scan at CH=3, first dwell sample, drop EN for 4 cycles.
  - O=4'h4 and CH=3 hold; O_VALID=0.
  - On EN=1: CH=3 once more, then 4.
- Mode switch and out-of-range:
  - Scan at CH=6, switch MODE=0 with S=1 -> O=4'h2, CH=1.
  - Back to MODE=1 -> CH restarts at 0.
  - With N_CH=6 (SEL_W=3), manual S=7 -> O=0, O_VALID=0.
- Reset mid-scan: rst_n=0 for one cycle at CH=4 -> all outputs 0. After release with EN=1, MODE=1 -> CH=0,0,1.
